mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//   Memory-side responder for the multicycle MIPS core's single shared memory port.
//   Serves instruction fetches and data loads/stores from a word-addressed RAM.
//   Decodes a small MMIO window: console TX FIFO, fault status, optional cycle counter.
//   Sits beside the CPU in the top-level; its console drains to a testbench or UART.
// PARAMETERS
//   DEPTH_WORDS  256            RAM size in 32-bit words; power of two, >= 2
//   FIFO_DEPTH   4              console FIFO entries; power of two, >= 2
//   MMIO_BASE    32'hFFFF_0000  base of the MMIO window; 16-byte aligned
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   rstb         in   1   asynchronous active-low reset
//   mem_addr     in   32  byte address from the CPU
//   mem_wr_data  in   32  store data from the CPU
//   mem_wr_ena   in   1   store strobe; write committed at posedge while high
//   mem_rd_data  out  32  read data; combinational from mem_addr
//   con_data     out  8   byte at the head of the console FIFO
//   con_valid    out  1   console FIFO not empty
//   con_ready    in   1   sink accepts con_data at posedge when con_valid=1
//   fault        out  1   OR of all sticky fault bits
// BEHAVIOUR
//   - Reset is asynchronous and active-low: always @(posedge clk or negedge rstb).
//     While rstb=0: FIFO empty (con_valid=0, con_data=0), fault reg=0, cycle count=0.
//     RAM contents are not reset. Reset mid-transfer discards any FIFO contents.
//   - Address decode ignores addr[1:0] for reads; word index = addr[31:2].
//     RAM:    addr < DEPTH_WORDS*4.
//     MMIO:   MMIO_BASE+0 CONSOLE, +4 CYCLES, +8 FAULT, +C reserved.
//     Anything else is unmapped.
//   - Reads have zero latency, because the CPU latches mem_rd_data at the next posedge.
//     RAM returns its word. CONSOLE returns {30'b0, full, empty}.
//     CYCLES returns the counter. FAULT returns {29'b0, fault_reg}.
//     Reserved and unmapped addresses return 32'hDEAD_BEEF.
//   - Writes commit at posedge when mem_wr_ena=1.
//     If addr[1:0]!=0, the write is discarded and fault_reg[0] is set (misaligned).
//     RAM: the whole word is written. There are no byte enables.
//     CONSOLE: pushes mem_wr_data[7:0]. If the FIFO is full and no pop occurs this cycle,
//       the byte is dropped and fault_reg[1] is set (overflow).
//     FAULT: each mem_wr_data[2:0] bit written as 1 clears that bit.
//       A fault raised in the same cycle wins over its clear.
//     CYCLES and reserved: write ignored.
//     Unmapped: write discarded and fault_reg[2] is set.
//   - Console FIFO: circular buffer with wrapping rd/wr pointers and a count of 0..FIFO_DEPTH.
//     Pop when con_valid && con_ready.
//     Push and pop in the same cycle leave count unchanged, including when full.
//     A push to an empty FIFO is visible on con_valid/con_data the next cycle (1-cycle latency).
//     con_data is the head entry, and 0 when empty.
//   - fault = |fault_reg. The bits are sticky until cleared or reset.
// CONFIGURATION
//   MMIO_CYCLE_COUNTER_EN defined:
//     32-bit counter increments every clk after reset and wraps 32'hFFFF_FFFF -> 0.
//     Reads at MMIO_BASE+4 return the pre-increment value of the current cycle.
//   MMIO_CYCLE_COUNTER_EN undefined:
//     No counter flops. MMIO_BASE+4 reads 32'h0. Writes there are ignored.
// TESTING
//   1. RAM write 0x1234_5678 @0x10, then read @0x10 and @0x13
//      -> both return 0x1234_5678; fault=0.
//   2. Write @0x12 (misaligned) -> RAM@0x10 unchanged; fault=1; FAULT reads 0x1.
//      Then write 0x1 to FAULT -> FAULT reads 0x0; fault=0.
//   3. con_ready=0; push 'A','B','C','D','E' -> CONSOLE reads 0x2 (full);
//      FAULT bit1=1; drain yields A,B,C,D only, then CONSOLE reads 0x1.
//   4. FIFO full and con_ready=1 in the same cycle as a CONSOLE push
//      -> count stays 4; no overflow fault; order preserved.
//   5. Read 0x0000_4000 and MMIO_BASE+0xC -> 0xDEAD_BEEF.
//      Write 0x0000_4000 -> FAULT bit2 set.
//   6. With MMIO_CYCLE_COUNTER_EN: release reset, read CYCLES after 10 clocks -> 10;
//      force counter to 0xFFFF_FFFF -> next read 0. Without the macro -> always 0.
//      Assert rstb low with 2 bytes in the FIFO -> con_valid=0 immediately.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Shared-port memory responder for the multicycle MIPS core: word RAM plus MMIO console/fault/cycles.
// Optional feature: define MMIO_CYCLE_COUNTER_EN to build the free-running cycle counter at MMIO_BASE+4.
module mips_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        fault
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [FW:0] FULL_CNT  = (FW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_ram [DEPTH_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] r_wr_ptr;
  logic [FW:0]   r_count;
  logic [2:0]    r_fault;
`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0]   r_cycles;
`endif

  logic        w_is_ram;
  logic        w_is_mmio;
  logic        w_unmapped;
  logic [1:0]  w_mmio_sel;
  logic        w_aligned;
  logic        w_wr;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_overflow;
  logic [2:0]  w_fault_set;
  logic [2:0]  w_fault_clr;
  logic [31:0] w_cycles;

  // RAM takes priority should the MMIO window ever be placed inside it.
  assign w_is_ram   = (mem_addr < RAM_BYTES);
  assign w_is_mmio  = !w_is_ram && (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign w_unmapped = !w_is_ram && !w_is_mmio;
  assign w_mmio_sel = mem_addr[3:2];
  assign w_aligned  = (mem_addr[1:0] == 2'b00);
  assign w_wr       = mem_wr_ena && w_aligned;

  assign w_empty    = (r_count == {(FW + 1){1'b0}});
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = !w_empty && con_ready;
  assign w_push_req = w_wr && w_is_mmio && (w_mmio_sel == 2'd0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overflow = w_push_req && w_full && !w_pop;

  assign w_fault_set = {w_wr && w_unmapped, w_overflow, mem_wr_ena && !w_aligned};
  assign w_fault_clr = (w_wr && w_is_mmio && (w_mmio_sel == 2'd2)) ? mem_wr_data[2:0] : 3'b000;

  assign con_valid = !w_empty;
  assign con_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign fault     = |r_fault;

`ifdef MMIO_CYCLE_COUNTER_EN
  assign w_cycles = r_cycles;

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cycles <= 32'h0000_0000;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
`else
  assign w_cycles = 32'h0000_0000;
`endif

  // Zero-latency read mux; the CPU captures mem_rd_data at the next edge.
  always_comb begin
    mem_rd_data = 32'hDEAD_BEEF;
    if (w_is_ram) begin
      mem_rd_data = r_ram[mem_addr[AW+1:2]];
    end else if (w_is_mmio) begin
      case (w_mmio_sel)
        2'd0:    mem_rd_data = {30'b0, w_full, w_empty};
        2'd1:    mem_rd_data = w_cycles;
        2'd2:    mem_rd_data = {29'b0, r_fault};
        default: mem_rd_data = 32'hDEAD_BEEF;
      endcase
    end else begin
      mem_rd_data = 32'hDEAD_BEEF;
    end
  end

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_wr && w_is_ram) begin
      r_ram[mem_addr[AW+1:2]] <= mem_wr_data;
    end
  end

  // Console FIFO pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_rd_ptr <= {FW{1'b0}};
      r_wr_ptr <= {FW{1'b0}};
      r_count  <= {(FW + 1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= 8'h00;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_wr_data[7:0];
        r_wr_ptr         <= r_wr_ptr + FW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FW + 1)'(1);
        2'b01:   r_count <= r_count - (FW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky fault bits: a raise in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_fault <= 3'b000;
    end else begin
      r_fault <= (r_fault & ~w_fault_clr) | w_fault_set;
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: behavioural RAM/FIFO/fault model checked every cycle,
// plus literal expectations on reads. Honours MMIO_CYCLE_COUNTER_EN if defined.
module tb_mips_mem_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        fault;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] m_ram [256];
  logic [7:0]  m_q [$];
  logic [2:0]  m_fault = 3'b000;
  logic [31:0] m_cycles = 32'd0;

  mips_mem_responder dut (
    .clk         (clk),
    .rstb        (rstb),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .con_data    (con_data),
    .con_valid   (con_valid),
    .con_ready   (con_ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < 32'd1024)          return m_ram[w[9:2]];
    if (w == BASE)             return {30'b0, m_q.size() == 4, m_q.size() == 0};
`ifdef MMIO_CYCLE_COUNTER_EN
    if (w == BASE + 32'd4)     return m_cycles;
`else
    if (w == BASE + 32'd4)     return 32'd0;
`endif
    if (w == BASE + 32'd8)     return {29'b0, m_fault};
    return 32'hDEAD_BEEF;
  endfunction

  // One clock edge of the model, using the inputs present at that edge.
  function automatic void model_step(input logic [31:0] a, input logic [31:0] d,
                                     input logic we, input logic rdy);
    int  sz0;
    logic pop;
    sz0 = m_q.size();
    pop = rdy && (sz0 != 0);
    if (pop) void'(m_q.pop_front());
    m_cycles = m_cycles + 32'd1;
    if (we) begin
      if (a[1:0] != 2'b00)                          m_fault[0] = 1'b1;
      else if (a < 32'd1024)                        m_ram[a[9:2]] = d;
      else if (a == BASE) begin
        if (sz0 == 4 && !pop)                       m_fault[1] = 1'b1;
        else                                        m_q.push_back(d[7:0]);
      end
      else if (a == BASE + 32'd8)                   m_fault = m_fault & ~d[2:0];
      else if (a == BASE + 32'd4 || a == BASE + 32'hC) m_fault = m_fault;
      else                                          m_fault[2] = 1'b1;
    end
  endfunction

  // Tasks start and end on a negedge; each consumes exactly one posedge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
    mem_addr = a; mem_wr_data = d; mem_wr_ena = we; con_ready = rdy;
    @(posedge clk);
    model_step(a, d, we, rdy);
    @(negedge clk);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    mem_addr = a; mem_wr_data = 32'd0; mem_wr_ena = 1'b0; con_ready = 1'b0;
    #1;
    check(nm, mem_rd_data, exp);
    check({nm, "_model"}, mem_rd_data, model_read(a));
    @(posedge clk);
    model_step(a, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  // Every-cycle comparison of the console and fault outputs against the model.
  always @(negedge clk) begin
    check("con_valid", {31'b0, con_valid}, {31'b0, m_q.size() != 0});
    check("con_data", {24'b0, con_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    check("fault", {31'b0, fault}, {31'b0, |m_fault});
  end

  initial begin
    rstb = 1'b0; mem_addr = 32'd0; mem_wr_data = 32'd0; mem_wr_ena = 1'b0; con_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_con_valid", {31'b0, con_valid}, 32'd0);
    check("rst_con_data", {24'b0, con_data}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    rstb = 1'b1;

    repeat (10) cyc(32'd0, 32'd0, 1'b0, 1'b0);
`ifdef MMIO_CYCLE_COUNTER_EN
    rd("cycles_10", BASE + 32'd4, 32'd10);
`else
    rd("cycles_10", BASE + 32'd4, 32'd0);
`endif
    cyc(BASE + 32'd4, 32'h55, 1'b1, 1'b0);
    rd("cycles_wr_ign", BASE + 32'd4, model_read(BASE + 32'd4));

    // RAM basics and boundaries
    cyc(32'h10, 32'h1234_5678, 1'b1, 1'b0);
    rd("ram_10", 32'h10, 32'h1234_5678);
    rd("ram_13", 32'h13, 32'h1234_5678);
    check("t1_fault", {31'b0, fault}, 32'd0);
    cyc(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cyc(32'h3FC, 32'hA5A5_5A5A, 1'b1, 1'b0);
    cyc(32'h200, 32'h0000_0001, 1'b1, 1'b0);
    rd("ram_0", 32'h0, 32'hFFFF_FFFF);
    rd("ram_last", 32'h3FF, 32'hA5A5_5A5A);
    rd("ram_200", 32'h200, 32'h0000_0001);
    rd("ram_end", 32'h400, 32'hDEAD_BEEF);

    // misaligned store
    cyc(32'h12, 32'hAAAA_5555, 1'b1, 1'b0);
    rd("mis_ram", 32'h10, 32'h1234_5678);
    check("mis_fault", {31'b0, fault}, 32'd1);
    rd("mis_freg", BASE + 32'd8, 32'h1);
    cyc(BASE + 32'd8, 32'h1, 1'b1, 1'b0);
    rd("clr_freg", BASE + 32'd8, 32'h0);
    check("clr_fault", {31'b0, fault}, 32'd0);

    // overflow with sink stalled
    for (int i = 0; i < 5; i++) cyc(BASE, 32'h41 + i, 1'b1, 1'b0);
    rd("ovf_console", BASE, 32'h2);
    rd("ovf_freg", BASE + 32'd8, 32'h2);
    for (int i = 0; i < 4; i++) begin
      check("drain1", {24'b0, con_data}, 32'h41 + i);
      cyc(32'd0, 32'd0, 1'b0, 1'b1);
    end
    rd("drained_console", BASE, 32'h1);
    cyc(BASE + 32'd8, 32'h7, 1'b1, 1'b0);

    // push into a full FIFO while it pops
    for (int i = 0; i < 4; i++) cyc(BASE, 32'h57 + i, 1'b1, 1'b0);
    cyc(BASE, 32'h35, 1'b1, 1'b1);
    rd("pp_console", BASE, 32'h2);
    check("pp_fault", {31'b0, fault}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain2", {24'b0, con_data}, (i < 3) ? 32'h58 + i : 32'h35);
      cyc(32'd0, 32'd0, 1'b0, 1'b1);
    end

    // unmapped and reserved
    rd("unmapped_rd", 32'h0000_4000, 32'hDEAD_BEEF);
    rd("reserved_rd", BASE + 32'hC, 32'hDEAD_BEEF);
    cyc(BASE + 32'hC, 32'h7, 1'b1, 1'b0);
    check("reserved_wr", {31'b0, fault}, 32'd0);
    cyc(32'h0000_4000, 32'h0, 1'b1, 1'b0);
    rd("unmapped_freg", BASE + 32'd8, 32'h4);
    cyc(BASE + 32'd8, 32'h4, 1'b1, 1'b0);
    check("unmapped_clr", {31'b0, fault}, 32'd0);

    // reset mid-transfer
    cyc(BASE, 32'h61, 1'b1, 1'b0);
    cyc(BASE, 32'h62, 1'b1, 1'b0);
    check("pre_rst_valid", {31'b0, con_valid}, 32'd1);
    #2;
    rstb = 1'b0;
    m_q.delete();
    m_fault = 3'b000;
    m_cycles = 32'd0;
    #1;
    check("async_rst_valid", {31'b0, con_valid}, 32'd0);
    check("async_rst_data", {24'b0, con_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    rd("ram_kept", 32'h10, 32'h1234_5678);
    rd("post_rst_console", BASE, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
